pwm_gen_multi: RTL and testbench

PWM_GEN_MULTI -- requirements
Module: pwm_gen_multi

---
 rtl/pwm_gen_pkg.sv | 17 +
 rtl/pwm_gen_channel.sv | 42 ++++
 rtl/pwm_gen_multi.sv | 109 ++++++++++
 tb/tb_pwm_gen_multi.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_gen_pkg.sv
// Shared constants for the multi-channel PWM generator: register map and default sizes.
package pwm_gen_pkg;

  localparam int DEF_CHANNELS = 4;
  localparam int DEF_WIDTH    = 8;
  localparam int DEF_PRESC_W  = 8;

  localparam int ADDR_PERIOD  = 0;
  localparam int ADDR_PRESC   = 1;
  localparam int ADDR_POL     = 2;
  localparam int ADDR_DUTY0   = 3;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/pwm_gen_channel.sv
// One PWM channel: duty shadow/active pair, compare against the shared counter, output flop.
module pwm_gen_channel
  import pwm_gen_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_en,
  input  logic             i_load,
  input  logic             i_wr,
  input  logic [WIDTH-1:0] i_wr_data,
  input  logic [WIDTH-1:0] i_cnt,
  input  logic             i_pol,
  output logic             o_pwm
);

  logic [WIDTH-1:0] r_duty_shadow;
  logic [WIDTH-1:0] r_duty_active;
  logic             r_pwm;
  logic             w_raw;

  assign w_raw = (i_cnt < r_duty_active);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_duty_shadow <= '0;
      r_duty_active <= '0;
      r_pwm         <= 1'b0;
    end else begin
      if (i_wr)
        r_duty_shadow <= i_wr_data;
      // Same-cycle write and load: active takes the pre-write shadow value.
      if (i_load)
        r_duty_active <= r_duty_shadow;
      r_pwm <= i_en & (w_raw ^ i_pol);
    end
  end

  assign o_pwm = r_pwm;

endmodule

// File: rtl/pwm_gen_multi.sv
// Multi-channel PWM generator: prescaler, shared period counter, register decode.
// Define PWM_GEN_POLARITY_EN to add the per-channel output polarity register at address 2.
module pwm_gen_multi
  import pwm_gen_pkg::*;
#(
  parameter int CHANNELS = DEF_CHANNELS,
  parameter int WIDTH    = DEF_WIDTH,
  parameter int PRESC_W  = DEF_PRESC_W
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  en,
  input  logic                                  wr_en,
  input  logic [$clog2(CHANNELS+3)-1:0]         wr_addr,
  input  logic [max_int(WIDTH, PRESC_W)-1:0]    wr_data,
  output logic [CHANNELS-1:0]                   pwm_out,
  output logic                                  period_done
);

  localparam int AW = $clog2(CHANNELS + 3);

  logic [PRESC_W-1:0]  r_prescale;
  logic [PRESC_W-1:0]  r_presc_cnt;
  logic [WIDTH-1:0]    r_period_shadow;
  logic [WIDTH-1:0]    r_period_active;
  logic [WIDTH-1:0]    r_cnt;
  logic                r_period_done;
  logic                w_tick;
  logic                w_wrap;
  logic                w_load;
  logic [CHANNELS-1:0] w_pol;

  // >= keeps the prescaler from running past a freshly lowered prescale value.
  assign w_tick = en && (r_presc_cnt >= r_prescale);
  assign w_wrap = w_tick && (r_cnt == r_period_active);
  assign w_load = w_wrap || !en;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_prescale      <= '0;
      r_presc_cnt     <= '0;
      r_period_shadow <= '0;
      r_period_active <= '0;
      r_cnt           <= '0;
      r_period_done   <= 1'b0;
    end else begin
      if (wr_en && (wr_addr == AW'(ADDR_PERIOD)))
        r_period_shadow <= wr_data[WIDTH-1:0];
      if (wr_en && (wr_addr == AW'(ADDR_PRESC)))
        r_prescale <= wr_data[PRESC_W-1:0];
      if (w_load)
        r_period_active <= r_period_shadow;

      if (!en) begin
        r_presc_cnt <= '0;
        r_cnt       <= '0;
      end else if (w_tick) begin
        r_presc_cnt <= '0;
        r_cnt       <= w_wrap ? '0 : r_cnt + WIDTH'(1);
      end else begin
        r_presc_cnt <= r_presc_cnt + PRESC_W'(1);
      end

      r_period_done <= w_wrap;
    end
  end

`ifdef PWM_GEN_POLARITY_EN
  localparam int PW = max_int(CHANNELS, max_int(WIDTH, PRESC_W));
  logic [PW-1:0]       w_data_ext;
  logic [CHANNELS-1:0] r_pol;

  assign w_data_ext = PW'(wr_data);

  // Polarity is not shadowed: it flips outputs from the next cycle on.
  always_ff @(posedge clk) begin
    if (rst)
      r_pol <= '0;
    else if (wr_en && (wr_addr == AW'(ADDR_POL)))
      r_pol <= w_data_ext[CHANNELS-1:0];
  end

  assign w_pol = r_pol;
`else
  assign w_pol = '0;
`endif

  genvar gi;
  generate
    for (gi = 0; gi < CHANNELS; gi++) begin : g_ch
      pwm_gen_channel #(
        .WIDTH (WIDTH)
      ) u_ch (
        .clk       (clk),
        .rst       (rst),
        .i_en      (en),
        .i_load    (w_load),
        .i_wr      (wr_en && (wr_addr == AW'(ADDR_DUTY0 + gi))),
        .i_wr_data (wr_data[WIDTH-1:0]),
        .i_cnt     (r_cnt),
        .i_pol     (w_pol[gi]),
        .o_pwm     (pwm_out[gi])
      );
    end
  endgenerate

  assign period_done = r_period_done;

endmodule

// File: tb/tb_pwm_gen_multi.sv
// Self-checking bench for pwm_gen_multi: per-cycle expectations queued and compared after each edge.
module tb_pwm_gen_multi;

  localparam int CH = 4;
  localparam int W  = 8;
  localparam int PS = 8;
  localparam int AW = $clog2(CH + 3);
  localparam int DW = (W > PS) ? W : PS;

  logic          clk = 1'b0;
  logic          rst;
  logic          en;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic [CH-1:0] pwm_out;
  logic          period_done;

  typedef struct packed {
    logic [CH-1:0] pwm;
    logic          done;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

`ifdef PWM_GEN_POLARITY_EN
  localparam logic [CH-1:0] POL_EXP = 4'b0001;
`else
  localparam logic [CH-1:0] POL_EXP = 4'b0000;
`endif

  pwm_gen_multi #(
    .CHANNELS (CH),
    .WIDTH    (W),
    .PRESC_W  (PS)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .pwm_out     (pwm_out),
    .period_done (period_done)
  );

  always #5 clk = ~clk;

  // Cycle j counts from the first cycle in which en=1 is sampled.
  function automatic logic exp_bit(input int j, input int s, input int p, input int d);
    int cnt;
    cnt = (j / (s + 1)) % (p + 1);
    return (cnt < d);
  endfunction

  function automatic logic exp_done(input int j, input int s, input int p);
    int len;
    len = (s + 1) * (p + 1);
    return ((j % len) == (len - 1));
  endfunction

  task automatic write_reg(input logic [AW-1:0] a, input logic [DW-1:0] d);
    wr_en   = 1'b1;
    wr_addr = a;
    wr_data = d;
    @(posedge clk); #1;
    wr_en   = 1'b0;
  endtask

  // Program registers while disabled, then idle one cycle so every shadow reaches active.
  task automatic configure(input int p, input int s, input int d0, input int d1,
                           input int d2, input int d3);
    en = 1'b0;
    write_reg(AW'(0), DW'(p));
    write_reg(AW'(1), DW'(s));
    write_reg(AW'(3), DW'(d0));
    write_reg(AW'(4), DW'(d1));
    write_reg(AW'(5), DW'(d2));
    write_reg(AW'(6), DW'(d3));
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    exp_t e, got;
    rst = 1'b1; en = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    for (int j = 0; j < 6; j++) begin
      if (j == 3) rst = 1'b0;
      e = '0;
      sb_q.push_back(e);
      @(posedge clk); #1;
      got = sb_q.pop_front();
      n_checks++;
      if (pwm_out !== got.pwm || period_done !== got.done) begin
        n_fail++;
        $display("FAIL reset_idle cycle %0d: got pwm=%b done=%b, expected pwm=%b done=%b",
                 j, pwm_out, period_done, got.pwm, got.done);
      end
    end
  endtask

  task automatic test_basic_duty();
    exp_t e, got;
    int   d[CH];
    d = '{3, 0, 10, 5};
    configure(9, 0, d[0], d[1], d[2], d[3]);
    en = 1'b1;
    for (int j = 0; j < 40; j++) begin
      for (int c = 0; c < CH; c++) e.pwm[c] = exp_bit(j, 0, 9, d[c]);
      e.done = exp_done(j, 0, 9);
      sb_q.push_back(e);
      @(posedge clk); #1;
      got = sb_q.pop_front();
      n_checks++;
      if (pwm_out !== got.pwm || period_done !== got.done) begin
        n_fail++;
        $display("FAIL basic_duty cycle %0d: got pwm=%b done=%b, expected pwm=%b done=%b",
                 j, pwm_out, period_done, got.pwm, got.done);
      end
    end
    en = 1'b0;
    e = '0;
    sb_q.push_back(e);
    @(posedge clk); #1;
    got = sb_q.pop_front();
    n_checks++;
    if (pwm_out !== got.pwm || period_done !== got.done) begin
      n_fail++;
      $display("FAIL disable cycle 0: got pwm=%b done=%b, expected pwm=%b done=%b",
               pwm_out, period_done, got.pwm, got.done);
    end
  endtask

  task automatic test_shadow();
    exp_t e, got;
    int   d[CH];
    int   p;
    d = '{3, 0, 10, 5};
    configure(9, 0, d[0], d[1], d[2], d[3]);
    en = 1'b1;
    for (int j = 0; j < 50; j++) begin
      // Mid-period write at 14; write at 29 lands on the wrap cycle.
      wr_en = (j == 14) || (j == 29);
      wr_addr = AW'(3);
      wr_data = (j == 14) ? DW'(7) : DW'(2);
      p = j / 10;
      d[0] = (p < 2) ? 3 : ((p < 4) ? 7 : 2);
      for (int c = 0; c < CH; c++) e.pwm[c] = exp_bit(j, 0, 9, d[c]);
      e.done = exp_done(j, 0, 9);
      sb_q.push_back(e);
      @(posedge clk); #1;
      got = sb_q.pop_front();
      n_checks++;
      if (pwm_out !== got.pwm || period_done !== got.done) begin
        n_fail++;
        $display("FAIL shadow cycle %0d: got pwm=%b done=%b, expected pwm=%b done=%b",
                 j, pwm_out, period_done, got.pwm, got.done);
      end
    end
    wr_en = 1'b0;
    en = 1'b0;
  endtask

  task automatic test_prescale_reset();
    exp_t e, got;
    int   d[CH];
    d = '{2, 0, 10, 5};
    configure(4, 3, d[0], d[1], d[2], d[3]);
    en = 1'b1;
    for (int j = 0; j < 45; j++) begin
      for (int c = 0; c < CH; c++) e.pwm[c] = exp_bit(j, 3, 4, d[c]);
      e.done = exp_done(j, 3, 4);
      sb_q.push_back(e);
      @(posedge clk); #1;
      got = sb_q.pop_front();
      n_checks++;
      if (pwm_out !== got.pwm || period_done !== got.done) begin
        n_fail++;
        $display("FAIL prescale cycle %0d: got pwm=%b done=%b, expected pwm=%b done=%b",
                 j, pwm_out, period_done, got.pwm, got.done);
      end
    end
    // Mid-period reset with en and a write both active: reset must win.
    rst = 1'b1;
    wr_en = 1'b1; wr_addr = AW'(0); wr_data = DW'(5);
    e = '0;
    sb_q.push_back(e);
    @(posedge clk); #1;
    got = sb_q.pop_front();
    n_checks++;
    if (pwm_out !== got.pwm || period_done !== got.done) begin
      n_fail++;
      $display("FAIL reset_mid cycle 0: got pwm=%b done=%b, expected pwm=%b done=%b",
               pwm_out, period_done, got.pwm, got.done);
    end
    rst = 1'b0;
    wr_en = 1'b0;
    // Cleared registers: period 0, prescale 0, duty 0 -> low outputs, wrap every cycle.
    for (int j = 0; j < 10; j++) begin
      for (int c = 0; c < CH; c++) e.pwm[c] = exp_bit(j, 0, 0, 0);
      e.done = exp_done(j, 0, 0);
      sb_q.push_back(e);
      @(posedge clk); #1;
      got = sb_q.pop_front();
      n_checks++;
      if (pwm_out !== got.pwm || period_done !== got.done) begin
        n_fail++;
        $display("FAIL after_reset cycle %0d: got pwm=%b done=%b, expected pwm=%b done=%b",
                 j, pwm_out, period_done, got.pwm, got.done);
      end
    end
    en = 1'b0;
  endtask

  task automatic test_polarity();
    exp_t e, got;
    int   d[CH];
    d = '{3, 0, 10, 5};
    en = 1'b0;
    write_reg(AW'(2), DW'(1));
    write_reg(AW'(7), DW'(8'hFF));
    configure(9, 0, d[0], d[1], d[2], d[3]);
    en = 1'b1;
    for (int j = 0; j < 30; j++) begin
      for (int c = 0; c < CH; c++) e.pwm[c] = exp_bit(j, 0, 9, d[c]) ^ POL_EXP[c];
      e.done = exp_done(j, 0, 9);
      sb_q.push_back(e);
      @(posedge clk); #1;
      got = sb_q.pop_front();
      n_checks++;
      if (pwm_out !== got.pwm || period_done !== got.done) begin
        n_fail++;
        $display("FAIL polarity cycle %0d: got pwm=%b done=%b, expected pwm=%b done=%b",
                 j, pwm_out, period_done, got.pwm, got.done);
      end
    end
    // Disabled: outputs forced low regardless of polarity.
    en = 1'b0;
    e = '0;
    sb_q.push_back(e);
    @(posedge clk); #1;
    got = sb_q.pop_front();
    n_checks++;
    if (pwm_out !== got.pwm || period_done !== got.done) begin
      n_fail++;
      $display("FAIL polarity_off cycle 0: got pwm=%b done=%b, expected pwm=%b done=%b",
               pwm_out, period_done, got.pwm, got.done);
    end
  endtask

  initial begin
    test_reset();
    test_basic_duty();
    test_shadow();
    test_prescale_reset();
    test_polarity();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
